// File: rtl/data_memory.sv
// Little-endian data memory for the single-cycle MIPS datapath.
// Loads are combinational with lane select and extension; stores commit on the clock edge.
module data_memory #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  input  logic [2:0]  DMType,
  output logic [31:0] RD,
  output logic        AddrErr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_word;
  logic [15:0]           w_half;
  logic [7:0]            w_byte;
  logic [3:0]            w_byte_en;
  logic [31:0]           w_bit_mask;
  logic [31:0]           w_wdata;
  logic                  w_misalign;
  logic                  w_reserved;
  logic                  w_we;
  logic                  w_unused_addr;

  // Address bits above the word index only alias, they never select anything.
  assign w_unused_addr = ^Addr[31:ADDR_WIDTH+2];

  assign w_idx  = Addr[ADDR_WIDTH+1:2];
  assign w_word = r_mem[w_idx];
  assign w_half = Addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    case (Addr[1:0])
      2'd0: w_byte = w_word[7:0];
      2'd1: w_byte = w_word[15:8];
      2'd2: w_byte = w_word[23:16];
      2'd3: w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  always_comb begin
    w_misalign = 1'b0;
    w_reserved = 1'b0;
    w_byte_en  = 4'b0000;
    w_wdata    = WD;
    case (DMType)
      3'd0: begin
        w_misalign = (Addr[1:0] != 2'b00);
        w_byte_en  = 4'b1111;
        w_wdata    = WD;
      end
      3'd1, 3'd2: begin
        w_misalign = Addr[0];
        w_byte_en  = Addr[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {WD[15:0], WD[15:0]};
      end
      3'd3, 3'd4: begin
        w_byte_en  = 4'b0001 << Addr[1:0];
        w_wdata    = {4{WD[7:0]}};
      end
      default: w_reserved = 1'b1;
    endcase
  end

  assign AddrErr = w_misalign | w_reserved;
  assign w_we    = MemWrite & ~AddrErr;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign w_bit_mask[8*gi +: 8] = {8{w_byte_en[gi]}};
    end
  endgenerate

  always_comb begin
    RD = 32'h0;
    if (!AddrErr) begin
      case (DMType)
        3'd0: RD = w_word;
        3'd1: RD = {{16{w_half[15]}}, w_half};
        3'd2: RD = {16'h0, w_half};
        3'd3: RD = {{24{w_byte[7]}}, w_byte};
        3'd4: RD = {24'h0, w_byte};
        default: RD = 32'h0;
      endcase
    end
  end

  // Reset wins over a concurrent store; unselected lanes keep their old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (w_we) begin
      r_mem[w_idx] <= (w_word & ~w_bit_mask) | (w_wdata & w_bit_mask);
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed-vector bench for data_memory: reset, lane assembly, extension,
// misalignment, read-during-write, reset/store collision and aliasing.
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic        MemWrite;
  logic [2:0]  DMType;
  logic [31:0] RD;
  logic        AddrErr;

  int checks;
  int errors;

  data_memory #(.ADDR_WIDTH(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .Addr     (Addr),
    .WD       (WD),
    .MemWrite (MemWrite),
    .DMType   (DMType),
    .RD       (RD),
    .AddrErr  (AddrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    Addr = a; WD = d; DMType = t; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] t);
    Addr = a; DMType = t; MemWrite = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; Addr = 32'h0; WD = 32'h0; MemWrite = 1'b0; DMType = 3'd0;
    @(posedge clk); #1;
    reset = 1'b0;

    load(32'h0, 3'd0);   check("reset_word0", RD, 32'h0);
    check("reset_err0", {31'h0, AddrErr}, 32'h0);

    // Reset clears a written word; pre-reset contents stay visible during the reset cycle
    store(32'h0, 32'hDEADBEEF, 3'd0);
    load(32'h0, 3'd0);   check("sw_dead", RD, 32'hDEADBEEF);
    reset = 1'b1;
    load(32'h0, 3'd0);   check("rst_cycle_old", RD, 32'hDEADBEEF);
    @(posedge clk); #1;
    reset = 1'b0;
    load(32'h0, 3'd0);   check("rst_cleared", RD, 32'h0);
    check("rst_cleared_err", {31'h0, AddrErr}, 32'h0);

    // Byte assembly with junk upper bits
    store(32'h10, 32'hFFFFFF11, 3'd3);
    store(32'h11, 32'hFFFFFF22, 3'd3);
    store(32'h12, 32'hFFFFFF33, 3'd4);
    store(32'h13, 32'hFFFFFF44, 3'd3);
    load(32'h10, 3'd0);  check("byte_asm", RD, 32'h44332211);
    load(32'h13, 3'd4);  check("lbu_lane3", RD, 32'h00000044);

    // Sign and zero extension
    store(32'h20, 32'h80FF7F80, 3'd0);
    load(32'h20, 3'd3);  check("lb_20", RD, 32'hFFFFFF80);
    load(32'h20, 3'd4);  check("lbu_20", RD, 32'h00000080);
    load(32'h21, 3'd3);  check("lb_21", RD, 32'h0000007F);
    load(32'h22, 3'd1);  check("lh_22", RD, 32'hFFFF80FF);
    load(32'h22, 3'd2);  check("lhu_22", RD, 32'h000080FF);
    load(32'h20, 3'd1);  check("lh_20", RD, 32'h00007F80);

    // Halfword store into upper lane
    store(32'h30, 32'h12345678, 3'd0);
    store(32'h32, 32'hAAAABBBB, 3'd1);
    load(32'h30, 3'd0);  check("sh_upper", RD, 32'hBBBB5678);

    // Read-during-write returns old data until the edge
    store(32'h40, 32'h11111111, 3'd0);
    Addr = 32'h40; WD = 32'h22222222; DMType = 3'd0; MemWrite = 1'b1;
    #1;                  check("rdw_old", RD, 32'h11111111);
    @(posedge clk); #1;
    MemWrite = 1'b0;
    load(32'h40, 3'd0);  check("rdw_new", RD, 32'h22222222);

    // Misaligned word store is flagged and suppressed
    Addr = 32'h31; WD = 32'hFFFFFFFF; DMType = 3'd0; MemWrite = 1'b1;
    #1;
    check("mis_sw_err", {31'h0, AddrErr}, 32'h1);
    check("mis_sw_rd", RD, 32'h0);
    @(posedge clk); #1;
    MemWrite = 1'b0;
    load(32'h30, 3'd0);  check("mis_sw_keep", RD, 32'hBBBB5678);
    load(32'h33, 3'd1);  check("mis_lh_err", {31'h0, AddrErr}, 32'h1);
    load(32'h31, 3'd2);  check("mis_lhu_err", {31'h0, AddrErr}, 32'h1);
    load(32'h33, 3'd3);  check("lb_33_err", {31'h0, AddrErr}, 32'h0);
    load(32'h33, 3'd3);  check("lb_33", RD, 32'hFFFFFFBB);

    // Reserved type: flagged and store suppressed
    Addr = 32'h30; WD = 32'h0; DMType = 3'd6; MemWrite = 1'b1;
    #1;
    check("rsv6_err", {31'h0, AddrErr}, 32'h1);
    check("rsv6_rd", RD, 32'h0);
    @(posedge clk); #1;
    MemWrite = 1'b0;
    load(32'h30, 3'd0);  check("rsv6_keep", RD, 32'hBBBB5678);
    load(32'h30, 3'd5);  check("rsv5_err", {31'h0, AddrErr}, 32'h1);

    // Reset collides with a store: store dropped, everything cleared
    store(32'h0, 32'h000000AA, 3'd0);
    reset = 1'b1;
    store(32'h0, 32'h00000055, 3'd0);
    reset = 1'b0;
    load(32'h0, 3'd0);   check("rst_collide", RD, 32'h0);
    load(32'h30, 3'd0);  check("rst_clear_30", RD, 32'h0);

    // Aliasing beyond 4 KiB
    store(32'h1000, 32'hCAFEF00D, 3'd0);
    load(32'h0, 3'd0);   check("alias_0", RD, 32'hCAFEF00D);
    load(32'h1004, 3'd0); check("alias_4", RD, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory (DM) for the single-cycle MIPS datapath. It is the consumer of the control unit's `MemWrite` and `DMType` signals. It performs byte, halfword and word loads and stores against an internal little-endian array, with sign or zero extension on loads and alignment checking. Reads are combinational within the instruction's cycle. Writes commit at the clock edge that ends the instruction.

## Interface
- `ADDR_WIDTH`, default 10: word-index width; array holds 2^ADDR_WIDTH 32-bit words (4 KiB at default).
- `clk  input  1`: the only clock; all state changes on its rising edge.
- `reset  input  1`: reset is synchronous and active-high; while high at a rising edge, every word is cleared to 0.
- `Addr  input  32`: byte address from the ALU result.
- `WD  input  32`: store data (rt value).
- `MemWrite  input  1`: store request for the current cycle.
- `DMType  input  3`: access type (encoding below).
- `RD  output  32`: load result, extended to 32 bits.
- `AddrErr  output  1`: the current access is misaligned or `DMType` is reserved.

## Operation
- `DMType` encoding:
  - 0: word (lw/sw).
  - 1: halfword, signed load (lh/sh).
  - 2: halfword, unsigned load (lhu).
  - 3: byte, signed load (lb/sb).
  - 4: byte, unsigned load (lbu).
  - 5–7: reserved.
- Word index is `Addr[ADDR_WIDTH+1:2]`. Bits above that are ignored, so addresses alias modulo 4·2^ADDR_WIDTH.
- Byte lanes are little-endian: lane k = word bits [8k+7:8k], selected by `Addr[1:0]`=k.
- Halfword lanes: `Addr[1]`=0 → bits [15:0]; `Addr[1]`=1 → bits [31:16].
- Alignment:
  - Word requires `Addr[1:0]`=0.
  - Halfword requires `Addr[0]`=0.
  - Byte is always aligned.
- `AddrErr` = misaligned OR `DMType` in 5–7. It is purely combinational and asserts regardless of `MemWrite`.
- Load path (combinational):
  - Selects the lane from the current array contents, then sign- or zero-extends per `DMType`.
  - Type 0 returns the whole word.
  - When `AddrErr`=1, `RD`=0.
- Store path (sequential): at a rising edge with `MemWrite`=1, `reset`=0 and `AddrErr`=0:
  - Word: writes `WD`.
  - Halfword (type 1 or 2): writes `WD[15:0]` into the selected halfword lane.
  - Byte (type 3 or 4): writes `WD[7:0]` into the selected byte lane.
  - Unselected lanes of the word are preserved.
- Misaligned or reserved store: suppressed entirely. The array is unchanged; no partial write occurs.
- Reset has priority over a store in the same cycle, so a store asserted during reset is dropped.

## Timing
- `RD` and `AddrErr` are valid in the same cycle as `Addr` and `DMType`, with zero latency.
- Stores become visible on `RD` in the cycle after the committing edge.
- Read-during-write to the same address returns the old contents for the whole cycle.
- Reset:
  - During the reset cycle, `RD` still reflects the pre-reset contents.
  - From the cycle after the reset edge, all words read 0, so a word load returns 0x00000000.
- Reset value of outputs: `RD`=0 for any aligned access after reset. `AddrErr` has no reset value because it is a function of inputs only.
- Back-to-back stores to the same word on consecutive edges accumulate lane-wise; there are no hazards inside the block.
- Reset raised mid-sequence (between stores) clears everything at that edge. Stores resume normally on the first edge with `reset`=0.

## Test plan
- Reset clears the array:
  - Write 0xDEADBEEF to 0x0, assert `reset` for one edge.
  - Word load at 0x0 → `RD`=0x00000000, `AddrErr`=0.
- Byte assembly:
  - Byte stores of 0x11, 0x22, 0x33, 0x44 at 0x10, 0x11, 0x12, 0x13 (`WD` upper bits junk = 0xFFFFFF00 | value).
  - Word load at 0x10 → 0x44332211.
- Extension:
  - Store word 0x80FF7F80 at 0x20.
  - lb at 0x20 → 0xFFFFFF80; lbu at 0x20 → 0x00000080; lb at 0x21 → 0x0000007F.
  - lh at 0x22 → 0xFFFF80FF; lhu at 0x22 → 0x000080FF.
- Halfword store:
  - With 0x12345678 at 0x30, store half `WD`=0xAAAABBBB at 0x32.
  - Word load at 0x30 → 0xBBBB5678.
- Misalignment:
  - Word store at 0x31 → `AddrErr`=1, `RD`=0, and 0x30 is unchanged.
  - Half load at 0x33 → `AddrErr`=1.
  - `DMType`=6 → `AddrErr`=1 and the store is suppressed.
- Reset/store collision and aliasing:
  - `reset`=1 with `MemWrite`=1, word 0x55 at 0x0 → 0x0 reads 0.
  - Word store 0xCAFEF00D at 0x1000 (default width) → word load at 0x0 returns 0xCAFEF00D.
